// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bin2bcd_pkg;

  // Converter FSM: load in IDLE, one double-dabble step per cycle in SHIFT,
  // hold the result in DONE until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS    = 4;
  localparam int DIGIT_W   = 4;
  localparam int SCRATCH_W = DIGITS * DIGIT_W;

  // Largest value the four-digit display can show.
  localparam int BCD_MAX = 9999;

  // Nibbles at or above this value get +3 before each shift.
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a binary producer, the converter and the digit consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: in_data/in_valid/in_ready (binary value in), out0..out3/out_valid/out_ready
// (BCD digits out, ones first), ovf only when BIN2BCD_SAT_EN is defined.
interface bin2bcd_seq_if #(
  parameter int W = 14
);
  import bin2bcd_pkg::*;

  logic [W-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] out0;
  logic [DIGIT_W-1:0] out1;
  logic [DIGIT_W-1:0] out2;
  logic [DIGIT_W-1:0] out3;
  logic               out_valid;
  logic               out_ready;
`ifdef BIN2BCD_SAT_EN
  logic               ovf;
`endif

`ifdef BIN2BCD_SAT_EN
  // Producer/consumer side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid, ovf
  );
  // Converter side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid, ovf
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid
  );
`endif

endinterface

// File: rtl/bin2bcd_seq_adj.sv
// Double-dabble nibble correction: values of 5 or more get +3 so the next shift carries.
// Latency: combinational.
// Backpressure: none.
// Ports: nib_in (scratch nibble before correction), nib_out (corrected nibble).
module bcd_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib_in,
  output logic [DIGIT_W-1:0] nib_out
);

  // Legal BCD inputs top out at 9, so 9+3 = 12 never wraps the nibble.
  assign nib_out = (nib_in >= ADD3_THRESH) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Latency: W cycles from accept edge to out_valid; one conversion per W+2 cycles at best.
// Backpressure: in_ready low while busy; out_valid and digits hold until out_ready.
// Ports: clk, rst_n (async, active low), bus (slave side of bin2bcd_seq_if).
// Build option BIN2BCD_SAT_EN: inputs above 9999 saturate to 9999 and raise ovf;
// without it, values above 9999 wrap modulo 10000 and there is no ovf.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  state_t               state, state_nxt;
  logic [W-1:0]         bin_q, bin_nxt, bin_shift, load_val;
  logic [SCRATCH_W-1:0] scr_q, scr_nxt, scr_adj, scr_shift;
  logic [SCRATCH_W-1:0] dig_q;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic                 live_q;
  logic                 accept;
  logic                 load_dig;
  logic                 unused_carry;

  // in_ready is gated by live_q so it stays low while reset is held and
  // rises one clock after release.
  assign bus.in_ready  = (state == IDLE) && live_q;
  assign bus.out_valid = (state == DONE);
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef BIN2BCD_SAT_EN
  logic [15:0] in_ext;
  logic        sat;
  logic        ovf_q;

  // Compare in a fixed 16-bit width so narrow W still builds; for W < 14
  // the comparison simply never fires.
  assign in_ext   = 16'(bus.in_data);
  assign sat      = in_ext > 16'(BCD_MAX);
  assign load_val = sat ? W'(BCD_MAX) : bus.in_data;
  assign bus.ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= sat;
    end
  end
`else
  assign load_val = bus.in_data;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_adj u_adj (
      .nib_in  (scr_q[i*DIGIT_W +: DIGIT_W]),
      .nib_out (scr_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  // Shift {scratch, binary} left by one; the bit leaving the thousands digit
  // is dropped, which is what makes 10000..16383 wrap modulo 10000.
  assign {unused_carry, scr_shift, bin_shift} = {scr_adj, bin_q, 1'b0};

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    load_dig  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bin_nxt   = load_val;
          scr_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bin_nxt = bin_shift;
        scr_nxt = scr_shift;
        cnt_nxt = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_nxt = DONE;
          load_dig  = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bin_q  <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      dig_q  <= '0;
      live_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      bin_q  <= bin_nxt;
      scr_q  <= scr_nxt;
      cnt_q  <= cnt_nxt;
      live_q <= 1'b1;
      // Digits take the post-shift scratch on the final step and then hold
      // until the next conversion completes, even across the handshake.
      if (load_dig) begin
        dig_q <= scr_shift;
      end
    end
  end

  assign bus.out0 = dig_q[0*DIGIT_W +: DIGIT_W];
  assign bus.out1 = dig_q[1*DIGIT_W +: DIGIT_W];
  assign bus.out2 = dig_q[2*DIGIT_W +: DIGIT_W];
  assign bus.out3 = dig_q[3*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: default-width instance plus a W=8 instance.
// Expected digits/latency are queued at accept and compared when out_valid rises.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  localparam int W  = 14;
  localparam int W8 = 8;

  typedef struct {
    logic [15:0] dig;
    int          acc;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t q8[$];

  bin2bcd_seq_if #(.W(W))  bus ();
  bin2bcd_seq_if #(.W(W8)) bus8 ();

  bin2bcd_seq #(.W(W))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bin2bcd_seq #(.W(W8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: decimal digits, saturated or wrapped per build.
  function automatic logic [15:0] model(input int v);
    int e;
`ifdef BIN2BCD_SAT_EN
    e = (v > 9999) ? 9999 : v;
`else
    e = v % 10000;
`endif
    return {4'(e / 1000 % 10), 4'(e / 100 % 10), 4'(e / 10 % 10), 4'(e % 10)};
  endfunction

  function automatic int digs();
    return int'({bus.out3, bus.out2, bus.out1, bus.out0});
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present v until accepted; returns the cycle number of the accept edge.
  task automatic send(input int v, output int acc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(v);
    while (!bus.in_ready && n < 60) begin
      tick();
      n++;
    end
    check("accept_rdy", int'(bus.in_ready), 1);
    acc = cyc + 1;
    q.push_back('{dig: model(v), acc: acc, ovf: (v > 9999)});
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic wait_done();
    int   n = 0;
    logic busy_rdy = 1'b0;
    while (!bus.out_valid && n < 40) begin
      busy_rdy |= bus.in_ready;
      tick();
      n++;
    end
    check("done_seen", int'(bus.out_valid), 1);
    check("busy_in_ready", int'(busy_rdy), 0);
  endtask

  // Scoreboard for the default-width instance.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && !prev) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("digits", digs(), int'(e.dig));
          check("latency", cyc - e.acc, W);
`ifdef BIN2BCD_SAT_EN
          check("ovf", int'(bus.ovf), int'(e.ovf));
`endif
        end
      end
      prev = bus.out_valid;
    end
  end

  // Scoreboard for the W=8 instance.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus8.out_valid && !prev) begin
        if (q8.size() == 0) begin
          check("unexpected_out8", 1, 0);
        end else begin
          e = q8.pop_front();
          check("digits8", int'({bus8.out3, bus8.out2, bus8.out1, bus8.out0}), int'(e.dig));
          check("latency8", cyc - e.acc, W8);
        end
      end
      prev = bus8.out_valid;
    end
  end

  initial begin
    int a1, a2, acc8, n;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    tick(2);

    // Reset state.
    check("rst_outputs", int'({bus.in_ready, bus.out_valid}), 0);
    check("rst_digits", digs(), 0);
`ifdef BIN2BCD_SAT_EN
    check("rst_ovf", int'(bus.ovf), 0);
`endif
    rst_n = 1'b1;
    tick();
    check("rdy_after_rst", int'(bus.in_ready), 1);

    // 1234 with the consumer stalled.
    send(1234, a1);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
    check("taken_1234", int'(bus.out_valid), 0);

    // 0 then 9999 back to back with out_ready held high.
    send(0, a1);
    send(9999, a2);
    check("b2b_spacing", a2 - a1, W + 2);
    wait_done();
    tick();

    // Backpressure on 0507; a stray 42 must be ignored.
    bus.out_ready = 1'b0;
    send(507, a1);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1);
      bus.in_data  = W'(42);
      check("bp_hold", int'({bus.out_valid, bus.in_ready, bus.out3, bus.out2, bus.out1, bus.out0}),
            int'({1'b1, 1'b0, 16'h0507}));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_taken", int'(bus.out_valid), 0);
    check("digits_kept", digs(), 16'h0507);

    // Overflow range.
    send(12000, a1);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
`ifdef BIN2BCD_SAT_EN
    send(8, a1);
    wait_done();
    tick();
`endif

    // Reset in the middle of 4321.
    send(4321, a1);
    tick(6);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_outputs", int'({bus.in_ready, bus.out_valid}), 0);
    check("midrst_digits", digs(), 0);
`ifdef BIN2BCD_SAT_EN
    check("midrst_ovf", int'(bus.ovf), 0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick();
    check("rdy_after_midrst", int'(bus.in_ready), 1);
    send(4321, a1);
    wait_done();
    tick();

    // Narrow instance: 255 in 8 cycles.
    bus8.out_ready = 1'b1;
    bus8.in_data   = 8'd255;
    bus8.in_valid  = 1'b1;
    check("rdy8", int'(bus8.in_ready), 1);
    acc8 = cyc + 1;
    q8.push_back('{dig: 16'h0255, acc: acc8, ovf: 1'b0});
    tick();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("done8_seen", int'(bus8.out_valid), 1);
    tick(3);

    check("queue_drained", q.size(), 0);
    check("queue8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that produces the four decimal digits consumed by the four-digit seven-segment decode/display path. Accepts one unsigned binary value per transaction, runs a shift-and-add-3 (double-dabble) conversion one bit per clock, and presents ones/tens/hundreds/thousands digits with a valid/ready handshake. It sits between counter/arithmetic logic and the display decoder, replacing combinational divide/modulo logic.

## Interface
Parameters:
- `W`: default 14. Binary input width; legal range 4..14; 14 covers 0..9999 plus overflow range up to 16383.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `in_data`: input, W bits. Unsigned binary value.
- `in_valid`: input, 1 bit. `in_data` is valid.
- `in_ready`: output, 1 bit. Converter can accept a value.
- `out0`: output, 4 bits. BCD ones digit.
- `out1`: output, 4 bits. BCD tens digit.
- `out2`: output, 4 bits. BCD hundreds digit.
- `out3`: output, 4 bits. BCD thousands digit.
- `out_valid`: output, 1 bit. Digits hold a completed result not yet taken.
- `out_ready`: input, 1 bit. Consumer takes the result.
- `ovf`: output, 1 bit. Last accepted value exceeded 9999. Only present with `BIN2BCD_SAT_EN`.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load `in_data` into the binary shift register and clear the 16-bit BCD scratch register.
  - Clear the bit counter, then go to SHIFT.
- **SHIFT**, each cycle:
  - Every scratch nibble ≥5 gets +3.
  - Then shift {scratch, binary} left by 1.
  - The bit shifted out of scratch[15] is discarded.
  - Counter increments; after the W-th shift, go to DONE.
- **Output update:** on the SHIFT→DONE edge, scratch nibbles [3:0],[7:4],[11:8],[15:12] are registered to `out0`..`out3`.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - On `out_ready`, go to IDLE.
  - Digits stay unchanged until the next DONE entry; they are not cleared on handshake.
- **Overflow without saturation:** discarding the carry beyond the thousands digit yields value mod 10000 for inputs 10000..16383.
- **Reset values:** all outputs, FSM (IDLE), counter and scratch are 0. `in_ready` is 1 one cycle after `rst_n` deasserts (it is combinational from IDLE state).

## Timing
- Accept edge: `in_valid`&`in_ready` sampled high at rising edge N.
- `out_valid` rises after edge N+W, so latency is W cycles (14 at default).
- Throughput: one conversion per W+2 cycles minimum (accept, W shifts, DONE handshake, return to IDLE).
- Inputs are not accepted in SHIFT or DONE. `in_data` changes outside the accept edge are ignored.
- Backpressure:
  - `out_valid` and digits hold indefinitely while `out_ready`=0.
  - `out_ready` high while `out_valid`=0 has no effect.
- Reset mid-operation (asynchronous, any state): immediate return to IDLE with outputs zero; the conversion is lost and no partial result is ever flagged valid.

## Configuration
- `BIN2BCD_SAT_EN` defined:
  - Input >9999 at accept is replaced by 9999 before conversion.
  - `ovf` is registered at accept, reset 0, and held until the next accept.
  - Latency is unchanged.
- `BIN2BCD_SAT_EN` undefined:
  - No `ovf` port and no comparator.
  - Results above 9999 wrap to value mod 10000.

## Structure
- Package `bin2bcd_pkg` contains:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Digit count constant (4).
  - BCD maximum constant (9999).
  - Add-3 threshold (5).
- Sub-module `bcd_adj`: combinational 4-bit nibble correction (≥5 → +3). Instantiated four times on the scratch register.

## Test plan
- Reset, then accept 1234: `out3..out0`=1,2,3,4, `out_valid` high exactly 14 cycles after the accept edge, `in_ready`=0 throughout.
- Accept 0 then 9999 back-to-back with `out_ready` tied high: results 0,0,0,0 then 9,9,9,9; second accept occurs 16 cycles after the first.
- Backpressure: after result 0507, hold `out_ready`=0 for 5 cycles. `out_valid`, digits 0,5,0,7 and `in_ready`=0 stay stable, and an `in_valid` pulse with 42 is ignored.
- Overflow, 12000:
  - With `BIN2BCD_SAT_EN`: digits 9,9,9,9 and `ovf`=1; a following 8 gives `ovf`=0.
  - Without it: digits 2,0,0,0.
- Assert `rst_n` low 7 cycles into a conversion of 4321: all outputs 0 immediately. After release, `in_ready`=1 and a fresh 4321 converts correctly.
- With `W`=8, accept 255: digits 0,2,5,5 with `out_valid` 8 cycles after accept.
